// File: rtl/intlv_pkg.sv
// Shared types and helpers for the interleaver-loop BIST sequencer.
package intlv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_CODEWORD_SIZE_IN_32 = 65;
    localparam int DEF_NUM_CODEWORDS       = 4;
    localparam int BLOCK_SIZE              = DEF_CODEWORD_SIZE_IN_32 * DEF_NUM_CODEWORDS;

    // Counters up to SAT_W bits wide are handled by zero-extending into sat_add.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input logic [SAT_W-1:0] max_v);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            sat_add = max_v;
        end else begin
            sat_add = sum[SAT_W-1:0];
        end
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/intlv_err_accum.sv
// Lock window, saturating word/bit error counters and optional first-error capture.
// Optional capture is built only when INTLV_BIST_FIRST_ERR_EN is defined.
module intlv_err_accum
    import intlv_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int LOCK_WORDS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             word_vld,
    input  logic [CNT_W-1:0] rx_idx,
    input  logic [31:0]      chk_err,
    output logic             err_any_nxt,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] err_bit_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [31:0]      first_err_syn
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             hit_s;

    // Words inside the lock window are the checker seeding itself and never count.
    always_comb begin
        hit_s  = word_vld && (rx_idx >= CNT_W'(LOCK_WORDS)) && (chk_err != 32'd0);
        word_d = word_q;
        bit_d  = bit_q;
        if (clr) begin
            word_d = '0;
            bit_d  = '0;
        end else if (hit_s) begin
            word_d = CNT_W'(sat_add(SAT_W'(word_q), SAT_W'(1), SAT_W'(CNT_MAX)));
            bit_d  = CNT_W'(sat_add(SAT_W'(bit_q), SAT_W'(popcount32(chk_err)), SAT_W'(CNT_MAX)));
        end else begin
            word_d = word_q;
        end
        err_any_nxt = (word_d != '0);
    end

    // Error counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            bit_q  <= '0;
        end else begin
            word_q <= word_d;
            bit_q  <= bit_d;
        end
    end

    assign err_word_cnt = word_q;
    assign err_bit_cnt  = bit_q;

`ifdef INTLV_BIST_FIRST_ERR_EN
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [31:0]      fsyn_q, fsyn_d;

    // A zero word counter means no counted error yet; saturation never returns it to zero.
    always_comb begin
        fidx_d = fidx_q;
        fsyn_d = fsyn_q;
        if (clr) begin
            fidx_d = '0;
            fsyn_d = 32'd0;
        end else if (hit_s && (word_q == '0)) begin
            fidx_d = rx_idx;
            fsyn_d = chk_err;
        end else begin
            fidx_d = fidx_q;
        end
    end

    // First-error capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fidx_q <= '0;
            fsyn_q <= 32'd0;
        end else begin
            fidx_q <= fidx_d;
            fsyn_q <= fsyn_d;
        end
    end

    assign first_err_idx = fidx_q;
    assign first_err_syn = fsyn_q;
`else
    assign first_err_idx = '0;
    assign first_err_syn = 32'd0;
`endif

endmodule

// File: rtl/intlv_bist_ctrl.sv
// BIST sequencer for the pre-interleaver / de-interleaver loop: FSM, tx/rx counts, timeout.
// Optional first-error capture enabled by INTLV_BIST_FIRST_ERR_EN.
module intlv_bist_ctrl
    import intlv_pkg::*;
#(
    parameter int CODEWORD_SIZE_IN_32 = DEF_CODEWORD_SIZE_IN_32,
    parameter int NUM_CODEWORDS       = DEF_NUM_CODEWORDS,
    parameter int CNT_W               = 32,
    parameter int TIMEOUT_CYC         = 4096,
    parameter int LOCK_WORDS          = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_num_blocks,
    input  logic             src_tready,
    output logic             src_tvalid,
    output logic             prbs_en,
    input  logic             sink_tvalid,
    input  logic [31:0]      chk_err,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             aborted,
    output logic             overrun,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] err_bit_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [31:0]      first_err_syn
);

    localparam int               IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] BLK_WORDS = CNT_W'(CODEWORD_SIZE_IN_32 * NUM_CODEWORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              src_tvalid_q, src_tvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              aborted_q, aborted_d;
    logic              overrun_q, overrun_d;

    logic              start_ok_s, in_run_s, accept_s, rx_word_s, go_done_s, err_any_s;
    logic [CNT_W-1:0]  tx_next_s, rx_next_s;

    // Next-state and registered-output computation for the whole sequencer.
    always_comb begin
        start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        in_run_s   = (state_q == ST_SEND) || (state_q == ST_DRAIN);
        accept_s   = src_tvalid_q && src_tready;
        rx_word_s  = sink_tvalid && in_run_s;
        tx_next_s  = accept_s  ? (tx_cnt_q + CNT_W'(1)) : tx_cnt_q;
        rx_next_s  = rx_word_s ? (rx_cnt_q + CNT_W'(1)) : rx_cnt_q;

        state_d      = state_q;
        total_d      = total_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        idle_d       = idle_q;
        src_tvalid_d = src_tvalid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        aborted_d    = aborted_q;
        overrun_d    = overrun_q;
        go_done_s    = 1'b0;

        case (state_q)
            ST_SEND: begin
                tx_cnt_d = tx_next_s;
                rx_cnt_d = rx_next_s;
                if (abort) begin
                    go_done_s = 1'b1;
                    aborted_d = 1'b1;
                end else if (accept_s && (tx_next_s == total_q)) begin
                    state_d      = ST_DRAIN;
                    src_tvalid_d = 1'b0;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DRAIN: begin
                rx_cnt_d = rx_next_s;
                idle_d   = sink_tvalid ? '0 : (idle_q + IDLE_W'(1));
                // Completion is tested before timeout, so a final word on the last idle slot passes.
                if (abort) begin
                    go_done_s = 1'b1;
                    aborted_d = 1'b1;
                end else if (rx_next_s == total_q) begin
                    go_done_s = 1'b1;
                end else if (idle_d == IDLE_W'(TIMEOUT_CYC)) begin
                    go_done_s = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (sink_tvalid) begin
                    overrun_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    overrun_d = overrun_q;
                end
                if (start_ok_s) begin
                    total_d   = CNT_W'(cfg_num_blocks) * BLK_WORDS;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    idle_d    = '0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    overrun_d = 1'b0;
                    if (cfg_num_blocks == 16'd0) begin
                        state_d      = ST_DONE;
                        src_tvalid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        pass_d       = 1'b1;
                    end else begin
                        state_d      = ST_SEND;
                        src_tvalid_d = 1'b1;
                        busy_d       = 1'b1;
                        done_d       = 1'b0;
                        pass_d       = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                src_tvalid_d = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b0;
                pass_d       = 1'b0;
            end
        endcase

        if (go_done_s) begin
            state_d      = ST_DONE;
            src_tvalid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            pass_d       = (rx_cnt_d == total_q) && !err_any_s && !timeout_d
                           && !aborted_d && !overrun_q;
        end else begin
            busy_d = busy_d;
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            total_q      <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            idle_q       <= '0;
            src_tvalid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            idle_q       <= idle_d;
            src_tvalid_q <= src_tvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            overrun_q    <= overrun_d;
        end
    end

    intlv_err_accum #(
        .CNT_W      (CNT_W),
        .LOCK_WORDS (LOCK_WORDS)
    ) u_err_accum (
        .clk           (clk),
        .rst           (rst),
        .clr           (start_ok_s),
        .word_vld      (rx_word_s),
        .rx_idx        (rx_cnt_q),
        .chk_err       (chk_err),
        .err_any_nxt   (err_any_s),
        .err_word_cnt  (err_word_cnt),
        .err_bit_cnt   (err_bit_cnt),
        .first_err_idx (first_err_idx),
        .first_err_syn (first_err_syn)
    );

    assign src_tvalid = src_tvalid_q;
    assign prbs_en    = src_tvalid_q & src_tready;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign aborted    = aborted_q;
    assign overrun    = overrun_q;
    assign tx_cnt     = tx_cnt_q;
    assign rx_cnt     = rx_cnt_q;

endmodule

// File: tb/tb_intlv_bist_ctrl.sv
// Directed bench for intlv_bist_ctrl: table of whole runs plus hand-written corner sequences.
module tb_intlv_bist_ctrl;

    localparam int CNT_W = 32;
`ifdef INTLV_BIST_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, abort, src_tready, sink_tvalid;
    logic [15:0]      cfg_num_blocks;
    logic [31:0]      chk_err;
    logic             src_tvalid, prbs_en, busy, done, pass, timeout, aborted, overrun;
    logic [CNT_W-1:0] tx_cnt, rx_cnt, err_word_cnt, err_bit_cnt, first_err_idx;
    logic [31:0]      first_err_syn;

    intlv_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_num_blocks(cfg_num_blocks),
        .src_tready(src_tready), .src_tvalid(src_tvalid), .prbs_en(prbs_en),
        .sink_tvalid(sink_tvalid), .chk_err(chk_err), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .aborted(aborted), .overrun(overrun), .tx_cnt(tx_cnt),
        .rx_cnt(rx_cnt), .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt),
        .first_err_idx(first_err_idx), .first_err_syn(first_err_syn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          blocks;
        bit          rnd;
        int          limit;
        bit          inj;
        int          exp_tx;
        int          exp_rx;
        int          exp_ew;
        int          exp_eb;
        bit          exp_pass;
        bit          exp_to;
        int          exp_drain;
        logic [31:0] exp_fidx;
        logic [31:0] exp_fsyn;
    } vec_t;

    vec_t vecs[5];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   acc, sunk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (prbs_en) acc++;
        if (sink_tvalid) sunk++;
        @(posedge clk);
        #1;
    endtask

    // Loop model: the sink returns each accepted word one or more cycles later.
    task automatic drive_sink(input int limit, input bit inj);
        if ((sunk < acc) && (sunk < limit)) begin
            sink_tvalid = 1'b1;
            if (inj && sunk == 0)       chk_err = 32'hFFFF_FFFF;
            else if (inj && sunk == 10) chk_err = 32'h0000_0101;
            else                        chk_err = 32'h0;
        end else begin
            sink_tvalid = 1'b0;
            chk_err     = 32'h0;
        end
    endtask

    task automatic do_run(input vec_t v);
        int cyc;
        int drain;
        bit lw;
        acc = 0; sunk = 0; drain = 0;
        cfg_num_blocks = 16'(v.blocks);
        start = 1'b1; src_tready = 1'b1; sink_tvalid = 1'b0; chk_err = 32'h0;
        step();
        start = 1'b0;
        chk("start_to_tvalid", 64'(src_tvalid), 64'd1);
        cyc = 0;
        while (!done && cyc < 8000) begin
            src_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_sink(v.limit, v.inj);
            lw = sink_tvalid && (sunk + 1 == v.exp_rx) && !v.exp_to;
            step();
            cyc++;
            if (busy && !src_tvalid) drain++;
            if (lw) chk("final_word_to_done", 64'(done), 64'd1);
        end
        sink_tvalid = 1'b0; chk_err = 32'h0;
        chk("run_done",       64'(done),          64'd1);
        chk("run_busy",       64'(busy),          64'd0);
        chk("tx_cnt",         64'(tx_cnt),        64'(v.exp_tx));
        chk("accepted_words", 64'(acc),           64'(v.exp_tx));
        chk("rx_cnt",         64'(rx_cnt),        64'(v.exp_rx));
        chk("err_word_cnt",   64'(err_word_cnt),  64'(v.exp_ew));
        chk("err_bit_cnt",    64'(err_bit_cnt),   64'(v.exp_eb));
        chk("pass",           64'(pass),          64'(v.exp_pass));
        chk("timeout",        64'(timeout),       64'(v.exp_to));
        chk("aborted",        64'(aborted),       64'd0);
        chk("overrun",        64'(overrun),       64'd0);
        chk("first_err_idx",  64'(first_err_idx), 64'(v.exp_fidx));
        chk("first_err_syn",  64'(first_err_syn), 64'(v.exp_fsyn));
        if (v.exp_drain != 0) chk("drain_cycles", 64'(drain), 64'(v.exp_drain));
    endtask

    initial begin
        int cyc;
        logic [CNT_W-1:0] tx_before;

        //            blk rnd limit inj tx   rx   ew eb pass to drain fidx                 fsyn
        vecs[0] = '{2, 1'b0, 9999, 1'b0, 520, 520, 0, 0, 1'b1, 1'b0, 0,    32'd0, 32'd0};
        vecs[1] = '{2, 1'b1, 9999, 1'b0, 520, 520, 0, 0, 1'b1, 1'b0, 0,    32'd0, 32'd0};
        vecs[2] = '{2, 1'b0, 9999, 1'b1, 520, 520, 1, 2, 1'b0, 1'b0, 0,
                    FE ? 32'd10 : 32'd0, FE ? 32'h0000_0101 : 32'd0};
        vecs[3] = '{2, 1'b0, 300,  1'b0, 520, 300, 0, 0, 1'b0, 1'b1, 4096, 32'd0, 32'd0};
        vecs[4] = '{1, 1'b0, 9999, 1'b0, 260, 260, 0, 0, 1'b1, 1'b0, 0,    32'd0, 32'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; src_tready = 1'b0; sink_tvalid = 1'b0;
        cfg_num_blocks = 16'd0; chk_err = 32'h0; acc = 0; sunk = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",       64'(busy),         64'd0);
        chk("rst_done",       64'(done),         64'd0);
        chk("rst_pass",       64'(pass),         64'd0);
        chk("rst_src_tvalid", 64'(src_tvalid),   64'd0);
        chk("rst_tx_cnt",     64'(tx_cnt),       64'd0);
        chk("rst_rx_cnt",     64'(rx_cnt),       64'd0);
        chk("rst_err_words",  64'(err_word_cnt), 64'd0);
        chk("rst_flags",      64'({timeout, aborted, overrun}), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) do_run(vecs[i]);

        // Sink word while DONE: overrun sets, pass drops, rx_cnt holds.
        sink_tvalid = 1'b1; step(); sink_tvalid = 1'b0;
        chk("ovr_overrun", 64'(overrun), 64'd1);
        chk("ovr_pass",    64'(pass),    64'd0);
        chk("ovr_rx_cnt",  64'(rx_cnt),  64'd260);
        chk("ovr_done",    64'(done),    64'd1);
        step();
        chk("ovr_sticky",  64'(overrun), 64'd1);

        // Abort at tx_cnt == 100.
        acc = 0; sunk = 0; cfg_num_blocks = 16'd2; start = 1'b1; step(); start = 1'b0;
        cyc = 0;
        while (tx_cnt != 32'd100 && cyc < 1000) begin
            src_tready = 1'b1; drive_sink(9999, 1'b0); step(); cyc++;
        end
        chk("abort_reach_tx100", 64'(tx_cnt), 64'd100);
        abort = 1'b1; src_tready = 1'b0; sink_tvalid = 1'b0; chk_err = 32'h0;
        step();
        abort = 1'b0;
        chk("abort_done",       64'(done),       64'd1);
        chk("abort_aborted",    64'(aborted),    64'd1);
        chk("abort_pass",       64'(pass),       64'd0);
        chk("abort_src_tvalid", 64'(src_tvalid), 64'd0);
        chk("abort_busy",       64'(busy),       64'd0);
        chk("abort_tx_cnt",     64'(tx_cnt),     64'd100);
        chk("abort_overrun",    64'(overrun),    64'd0);

        // Zero-block start together with abort in DONE: start wins.
        cfg_num_blocks = 16'd0; start = 1'b1; abort = 1'b1; src_tready = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("zero_done",    64'(done),    64'd1);
        chk("zero_pass",    64'(pass),    64'd1);
        chk("zero_aborted", 64'(aborted), 64'd0);
        chk("zero_counts",  64'({tx_cnt, rx_cnt}), 64'd0);
        chk("zero_errs",    64'({err_word_cnt, err_bit_cnt}), 64'd0);
        chk("zero_busy",    64'({busy, src_tvalid, timeout}), 64'd0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_in_done_ignored", 64'({aborted, done, pass}), 64'b011);

        // Start while busy is ignored, then asynchronous reset mid-run.
        acc = 0; sunk = 0; cfg_num_blocks = 16'd1; start = 1'b1; step(); start = 1'b0;
        repeat (20) begin
            src_tready = 1'b1; drive_sink(9999, 1'b0); step();
        end
        tx_before = tx_cnt;
        src_tready = 1'b1; sink_tvalid = 1'b0; start = 1'b1; step(); start = 1'b0;
        chk("start_while_busy_tx", 64'(tx_cnt), 64'(tx_before + 32'd1));
        chk("start_while_busy",    64'(busy),   64'd1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_ctrl",   64'({busy, done, pass, src_tvalid, prbs_en}), 64'd0);
        chk("midrst_counts", 64'({tx_cnt, rx_cnt}), 64'd0);
        chk("midrst_flags",  64'({timeout, aborted, overrun}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        src_tready = 1'b0;
        step();
        chk("post_rst_idle", 64'({busy, done, src_tvalid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
